// File: rtl/pic_int_ack_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pic_int_ack_sequencer_pkg
// Description : Shared types, constants and helpers for the PIC acknowledge
//               sequencer (FSM states, EOI type encoding, vector helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package pic_int_ack_sequencer_pkg;

    localparam int NUM_IR = 8;
    localparam int IDX_W  = 3;

    localparam logic             C_EOI_NONSPECIFIC = 1'b0;
    localparam logic             C_EOI_SPECIFIC    = 1'b1;
    localparam logic [IDX_W-1:0] C_SPURIOUS_IDX    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } state_t;

    function automatic logic [NUM_IR-1:0] idx_to_mask(input logic [IDX_W-1:0] idx);
        idx_to_mask = {{(NUM_IR-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [7:0] vector_byte(input logic [4:0]       base,
                                               input logic [IDX_W-1:0] idx);
        vector_byte = {base, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pic_int_ack_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pic_int_ack_sequencer_if
// Description : IR/IMR, control, INTA/EOI handshake and vector-bus signals of
//               the PIC acknowledge sequencer, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface pic_int_ack_sequencer_if
    import pic_int_ack_sequencer_pkg::*;
();

    logic [NUM_IR-1:0] ir;
    logic [NUM_IR-1:0] imr;
    logic              ltim;
    logic              aeoi;
    logic [4:0]        vec_base;
    logic              inta_n;
    logic              eoi_valid;
    logic              eoi_specific;
    logic [IDX_W-1:0]  eoi_level;
    logic              int_out;
    logic [7:0]        data_out;
    logic              data_oe;
    logic [NUM_IR-1:0] irr;
    logic [NUM_IR-1:0] isr;

    modport master (
        output ir, imr, ltim, aeoi, vec_base, inta_n,
               eoi_valid, eoi_specific, eoi_level,
        input  int_out, data_out, data_oe, irr, isr
    );

    modport slave (
        input  ir, imr, ltim, aeoi, vec_base, inta_n,
               eoi_valid, eoi_specific, eoi_level,
        output int_out, data_out, data_oe, irr, isr
    );

endinterface
`default_nettype wire

// File: rtl/pic_int_ack_sequencer_priority_resolver.sv
`default_nettype none
// ============================================================================
// Module      : pic_priority_resolver
// Description : Fixed-priority resolver; reports whether any bit is set and
//               the index of the lowest set bit (bit 0 is highest priority).
// Revision    : 1.0 - initial release
// ============================================================================
module pic_priority_resolver
    import pic_int_ack_sequencer_pkg::*;
(
    input  logic [NUM_IR-1:0] i_req,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pic_int_ack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pic_int_ack_sequencer
// Description : 8259A-style interrupt-acknowledge controller: IRR/ISR, fixed
//               priority, INT generation, two-pulse INTA and EOI/AEOI service.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_int_ack_sequencer
    import pic_int_ack_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    pic_int_ack_sequencer_if.slave  bus
);

    logic [NUM_IR-1:0] r_irr;
    logic [NUM_IR-1:0] r_isr;
    logic [NUM_IR-1:0] r_ir_prev;
    logic              r_inta_prev;
    logic              r_int_out;
    logic [7:0]        r_data_out;
    logic              r_data_oe;
    logic [IDX_W-1:0]  r_idx;
    logic              r_spurious;
    state_t            r_state;

    state_t            w_state_next;
    logic [NUM_IR-1:0] w_pend;
    logic              w_pw;
    logic [IDX_W-1:0]  w_pidx;
    logic              w_iw;
    logic [IDX_W-1:0]  w_iidx;
    logic              w_qualify;
    logic              w_inta_fall;
    logic              w_inta_rise;
    logic              w_ack1;
    logic              w_ack2;
    logic              w_ack_done;
    logic              w_grant;
    logic [NUM_IR-1:0] w_ir_rise;
    logic [NUM_IR-1:0] w_ack_mask;
    logic [NUM_IR-1:0] w_irr_next;
    logic [NUM_IR-1:0] w_isr_clr;
    logic [NUM_IR-1:0] w_isr_set;
    logic [NUM_IR-1:0] w_isr_next;

    assign w_pend = r_irr & ~bus.imr;

    pic_priority_resolver u_pend_resolver (
        .i_req   (w_pend),
        .o_valid (w_pw),
        .o_idx   (w_pidx)
    );

    pic_priority_resolver u_isr_resolver (
        .i_req   (r_isr),
        .o_valid (w_iw),
        .o_idx   (w_iidx)
    );

    // A pending request must outrank everything already in service.
    assign w_qualify   = w_pw && (!w_iw || (w_pidx < w_iidx));
    assign w_inta_fall = r_inta_prev & ~bus.inta_n;
    assign w_inta_rise = ~r_inta_prev & bus.inta_n;

    always_comb begin
        w_state_next = r_state;
        w_ack1       = 1'b0;
        w_ack2       = 1'b0;
        w_ack_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_inta_fall) begin
                    w_ack1       = 1'b1;
                    w_state_next = ST_ACK1;
                end
            end
            ST_ACK1: begin
                // inta_n was low on entry, so any fall here follows a rise.
                if (w_inta_fall) begin
                    w_ack2       = 1'b1;
                    w_state_next = ST_ACK2;
                end
            end
            ST_ACK2: begin
                if (w_inta_rise) begin
                    w_ack_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_grant    = w_ack1 & w_qualify;
    assign w_ack_mask = w_grant ? idx_to_mask(w_pidx) : '0;
    assign w_ir_rise  = bus.ir & ~r_ir_prev;

    // Level mode re-follows ir next cycle, so the acknowledge clear is one cycle.
    assign w_irr_next = (bus.ltim ? bus.ir : ((r_irr | w_ir_rise) & bus.ir)) & ~w_ack_mask;

    always_comb begin
        w_isr_clr = '0;
        if (bus.eoi_valid) begin
            if (bus.eoi_specific == C_EOI_SPECIFIC) begin
                w_isr_clr = idx_to_mask(bus.eoi_level);
            end else if (w_iw) begin
                w_isr_clr = idx_to_mask(w_iidx);
            end
        end
        if (w_ack_done && bus.aeoi && !r_spurious) begin
            w_isr_clr = w_isr_clr | idx_to_mask(r_idx);
        end
        w_isr_set  = w_grant ? idx_to_mask(w_pidx) : '0;
        // Clears first, then the INTA1 set, so a freshly granted bit survives.
        w_isr_next = (r_isr & ~w_isr_clr) | w_isr_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_irr       <= '0;
            r_isr       <= '0;
            r_ir_prev   <= '0;
            r_inta_prev <= 1'b1;
            r_int_out   <= 1'b0;
            r_data_out  <= '0;
            r_data_oe   <= 1'b0;
            r_idx       <= '0;
            r_spurious  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_irr       <= w_irr_next;
            r_isr       <= w_isr_next;
            r_ir_prev   <= bus.ir;
            r_inta_prev <= bus.inta_n;
            r_int_out   <= (r_state == ST_IDLE) && !w_inta_fall && w_qualify;
            if (w_ack1) begin
                r_idx      <= w_qualify ? w_pidx : C_SPURIOUS_IDX;
                r_spurious <= !w_qualify;
            end
            if (w_ack2) begin
                r_data_out <= vector_byte(bus.vec_base, r_idx);
                r_data_oe  <= 1'b1;
            end
            if (w_ack_done) begin
                r_data_oe <= 1'b0;
            end
        end
    end

    assign bus.int_out  = r_int_out;
    assign bus.data_out = r_data_out;
    assign bus.data_oe  = r_data_oe;
    assign bus.irr      = r_irr;
    assign bus.isr      = r_isr;

endmodule
`default_nettype wire

// File: tb/tb_pic_int_ack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_int_ack_sequencer
// Description : Directed self-checking bench for pic_int_ack_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_int_ack_sequencer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    pic_int_ack_sequencer_if bus ();

    pic_int_ack_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic eoi(input logic specific, input logic [2:0] level);
        bus.eoi_valid    = 1'b1;
        bus.eoi_specific = specific;
        bus.eoi_level    = level;
        step(1);
        bus.eoi_valid    = 1'b0;
    endtask

    task automatic inta_seq(input string tag, input logic [7:0] exp_vec);
        bus.inta_n = 1'b0;
        step(1);
        chk({tag, "_int_ack1"}, bus.int_out, 1'b0);
        chk({tag, "_oe_ack1"}, bus.data_oe, 1'b0);
        bus.inta_n = 1'b1;
        step(1);
        chk({tag, "_int_gap"}, bus.int_out, 1'b0);
        bus.inta_n = 1'b0;
        step(1);
        chk({tag, "_vec"}, bus.data_out, exp_vec);
        chk({tag, "_oe_ack2"}, bus.data_oe, 1'b1);
        bus.inta_n = 1'b1;
        step(1);
        chk({tag, "_oe_end"}, bus.data_oe, 1'b0);
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        reset            = 1'b1;
        bus.ir           = 8'h00;
        bus.imr          = 8'h00;
        bus.ltim         = 1'b0;
        bus.aeoi         = 1'b0;
        bus.vec_base     = 5'b01000;
        bus.inta_n       = 1'b1;
        bus.eoi_valid    = 1'b0;
        bus.eoi_specific = 1'b0;
        bus.eoi_level    = 3'd0;
        step(2);
        reset = 1'b0;
        chk("rst_irr", bus.irr, 8'h00);
        chk("rst_isr", bus.isr, 8'h00);
        chk("rst_int", bus.int_out, 1'b0);
        chk("rst_dout", bus.data_out, 8'h00);
        chk("rst_oe", bus.data_oe, 1'b0);

        // 1: single edge request on IR3
        bus.ir = 8'h08;
        step(1);
        chk("t1_irr", bus.irr, 8'h08);
        chk("t1_int_lat1", bus.int_out, 1'b0);
        step(1);
        chk("t1_int_lat2", bus.int_out, 1'b1);
        inta_seq("t1", 8'h43);
        chk("t1_isr", bus.isr, 8'h08);
        chk("t1_irr_clr", bus.irr, 8'h00);
        bus.ir = 8'h00;
        eoi(1'b0, 3'd0);
        chk("t1_eoi", bus.isr, 8'h00);

        // 2: simultaneous IR5/IR2, IR2 wins; IR5 waits for EOI
        bus.ir = 8'h24;
        step(2);
        chk("t2_int", bus.int_out, 1'b1);
        inta_seq("t2a", 8'h42);
        chk("t2_isr_a", bus.isr, 8'h04);
        chk("t2_irr_a", bus.irr, 8'h20);
        step(2);
        chk("t2_int_blk", bus.int_out, 1'b0);
        eoi(1'b0, 3'd0);
        chk("t2_eoi", bus.isr, 8'h00);
        step(1);
        chk("t2_int_re", bus.int_out, 1'b1);
        inta_seq("t2b", 8'h45);
        chk("t2_isr_b", bus.isr, 8'h20);
        chk("t2_irr_b", bus.irr, 8'h00);
        bus.ir = 8'h00;
        eoi(1'b0, 3'd0);
        chk("t2_eoi_b", bus.isr, 8'h00);

        // 3: lower-priority IR6 blocked by IR2 in service; IR1 nests
        bus.ir = 8'h04;
        step(2);
        inta_seq("t3a", 8'h42);
        chk("t3_isr_a", bus.isr, 8'h04);
        bus.ir = 8'h44;
        step(3);
        chk("t3_irr6", bus.irr, 8'h40);
        chk("t3_int_blk", bus.int_out, 1'b0);
        bus.ir = 8'h46;
        step(2);
        chk("t3_int_nest", bus.int_out, 1'b1);
        inta_seq("t3b", 8'h41);
        chk("t3_isr_nest", bus.isr, 8'h06);
        bus.ir = 8'h00;
        eoi(1'b0, 3'd0);
        chk("t3_eoi1", bus.isr, 8'h04);
        eoi(1'b0, 3'd0);
        chk("t3_eoi2", bus.isr, 8'h00);
        step(1);
        chk("t3_int_idle", bus.int_out, 1'b0);

        // 4: spurious acknowledge
        inta_seq("t4", 8'h47);
        chk("t4_isr", bus.isr, 8'h00);

        // 5: AEOI with level-triggered IR0 held high
        bus.aeoi = 1'b1;
        bus.ltim = 1'b1;
        bus.ir   = 8'h01;
        step(2);
        chk("t5_int", bus.int_out, 1'b1);
        inta_seq("t5", 8'h40);
        chk("t5_isr_aeoi", bus.isr, 8'h00);
        step(1);
        chk("t5_int_re", bus.int_out, 1'b1);
        chk("t5_irr", bus.irr, 8'h01);
        bus.ir = 8'h00;
        step(2);
        chk("t5_int_off", bus.int_out, 1'b0);
        bus.aeoi = 1'b0;
        bus.ltim = 1'b0;
        step(1);

        // 6: specific EOI, then reset in the middle of a handshake
        bus.ir = 8'h10;
        step(2);
        inta_seq("t6a", 8'h44);
        bus.ir = 8'h14;
        step(2);
        chk("t6_int_nest", bus.int_out, 1'b1);
        inta_seq("t6b", 8'h42);
        chk("t6_isr14", bus.isr, 8'h14);
        eoi(1'b1, 3'd4);
        chk("t6_spec_eoi", bus.isr, 8'h04);
        bus.ir = 8'h16;
        step(2);
        chk("t6_int_ir1", bus.int_out, 1'b1);
        bus.inta_n = 1'b0;
        step(1);
        chk("t6_isr_ack1", bus.isr, 8'h06);
        reset      = 1'b1;
        bus.inta_n = 1'b1;
        bus.ir     = 8'h00;
        #1;
        chk("t6_rst_oe", bus.data_oe, 1'b0);
        chk("t6_rst_irr", bus.irr, 8'h00);
        chk("t6_rst_isr", bus.isr, 8'h00);
        chk("t6_rst_int", bus.int_out, 1'b0);
        step(1);
        reset = 1'b0;
        step(1);
        // From IDLE with nothing pending this must be a spurious IR7 cycle.
        inta_seq("t6c", 8'h47);
        chk("t6_isr_end", bus.isr, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
